axis_bitflip_arb: RTL and testbench
===================================

Name: axis_bitflip_arb

Overview:
- Packet-granular round-robin arbiter that shares one downstream axis_bitflip engine among NUM_SRC AXI-Stream sources.
- Locks the grant to one source from the first beat of a packet until its TLAST beat is accepted.
- Drives a registered skid-buffer output stage that feeds the bitflip S_AXIS port.
- Tags every output beat with the source index on M_AXIS_TDEST so downstream logic can route the inverted result.

Parameters:
- NUM_SRC, 4, number of requesting sources, 2..8.
- DATA_W, 32, TDATA width; TKEEP width is DATA_W/8.
- SEL_W, 2, grant/TDEST index width; must satisfy 2**SEL_W >= NUM_SRC.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset; asynchronous, active-low.
- S_AXIS_TDATA  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- S_AXIS_TKEEP  in  NUM_SRC*DATA_W/8  source byte keeps, packed the same way.
- S_AXIS_TLAST  in  NUM_SRC  per-source last.
- S_AXIS_TVALID  in  NUM_SRC  per-source valid.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready; one-hot or zero.
- M_AXIS_TDATA  out  DATA_W  to bitflip.
- M_AXIS_TKEEP  out  DATA_W/8  to bitflip.
- M_AXIS_TLAST  out  1  to bitflip.
- M_AXIS_TDEST  out  SEL_W  index of the source that produced the beat.
- M_AXIS_TVALID  out  1  to bitflip.
- M_AXIS_TREADY  in  1  from bitflip.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All M_AXIS_* outputs go to 0.
  - S_AXIS_TREADY goes to 0.
  - FSM goes to IDLE.
  - last_grant goes to NUM_SRC-1, so source 0 wins first.
  - Skid buffer is emptied.
- FSM IDLE:
  - S_AXIS_TREADY = 0.
  - If any S_AXIS_TVALID bit is high, select the first valid source searching upward from last_grant+1, wrapping modulo NUM_SRC.
  - Register that index as grant and move to BUSY on the next edge; this is one cycle of arbitration latency.
  - TVALID changes during IDLE are re-evaluated every cycle.
- FSM BUSY:
  - S_AXIS_TREADY[grant] = skid buffer not full; all other ready bits are 0.
  - An accepted input beat (valid and ready both high) is written into the skid buffer together with TDEST = grant.
  - On an accepted beat with TLAST = 1: set last_grant to grant and return to IDLE.
  - Back-to-back packets therefore have a gap of at least one idle cycle on the input side.
- Skid buffer:
  - Two entries; all M_AXIS outputs are driven from registers.
  - Full throughput: one beat per cycle while M_AXIS_TREADY is high.
  - Input-to-output latency: 1 cycle.
  - Output data is held stable while TVALID is high and TREADY is low (AXIS rule).
  - Simultaneous push and pop while holding 1 entry: occupancy stays 1.
  - Full (2 entries): input ready drops in the same cycle, combinationally from registered occupancy.
  - Empty: M_AXIS_TVALID = 0.
- Grant invariant: a source that drops TVALID mid-packet keeps the grant; the arbiter waits and never switches before TLAST.
- Single-beat packets (TLAST on the first beat): IDLE -> BUSY -> IDLE, 1 beat.
- Reset mid-packet: the partial packet is discarded, the buffer is flushed, and no TLAST is emitted.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 packets.

Optional Feature:
- Macro: ARB_PKT_CNT_EN.
- Defined:
  - Adds output port PKT_CNT [31:0].
  - PKT_CNT increments by 1 on every M_AXIS beat accepted with TLAST = 1, wrapping 0xFFFFFFFF -> 0.
  - Reset value is 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package axis_arb_pkg:
  - FSM state enum {ST_IDLE, ST_BUSY}.
  - Default DATA_W.
  - Function rr_next(req, last) returning the next grant index.
- One sub-module, axis_skid_buf: 2-entry register slice with parameter WIDTH; payload is {TDEST, TLAST, TKEEP, TDATA}.
- The arbiter FSM and mux stay in the top module.

Test Plan:
- Reset release with S_AXIS_TVALID=4'b0000 -> M_AXIS_TVALID=0, S_AXIS_TREADY=0 indefinitely, PKT_CNT=0.
- Sources 0..3 all valid, each sending a 3-beat packet with data 0xA0+i -> output order src0, src1, src2, src3; TDEST matches the source; TLAST on beats 3, 6, 9, 12; PKT_CNT=4.
- Source 2 sends 4 beats and drops TVALID for 5 cycles after beat 2 while source 1 is valid -> no beat from source 1 appears until source 2's TLAST is accepted.
- M_AXIS_TREADY toggles 1,0,0,1 during a 6-beat packet 0x11..0x16 -> data unchanged while stalled; all 6 beats in order; no loss or duplication; input ready drops after 2 stalled beats.
- Source 3 alone streams single-beat packets with TREADY held at 1 -> one beat every 2 cycles (arbitration gap); TDEST=3 on each.
- ARESETN pulsed low mid-packet (beat 2 of 5) -> M_AXIS_TVALID=0 at once; after release, arbitration restarts at source 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the axis_bitflip_arb source arbiter.
package axis_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int MAX_SRC    = 8;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_e;

    // First requester strictly after `last`, wrapping modulo n; holds `last` when nothing requests.
    function automatic logic [2:0] rr_next(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         last,
        input int                 n
    );
        logic [2:0] sel;
        int         idx;
        sel = last;
        // Walk from the farthest candidate down so the nearest one is assigned last and wins.
        for (int k = MAX_SRC; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx]) sel = 3'(idx);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: registered outputs, full throughput, one cycle latency.
module axis_skid_buf
    import axis_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0]       cnt;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy, so no path from out_ready to in_ready.
    assign in_ready = (cnt != 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            skid_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        cnt       <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: out_data <= in_data;
                        2'b10: begin
                            skid_q <= in_data;
                            cnt    <= 2'd2;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            cnt       <= 2'd0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        out_data <= skid_q;
                        cnt      <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_bitflip_arb.sv
// Packet-granular round-robin arbiter feeding one bitflip engine; TDEST carries the source index.
// Optional ARB_PKT_CNT_EN adds PKT_CNT, a count of output packets (TLAST beats accepted).
module axis_bitflip_arb
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [NUM_SRC*DATA_W-1:0]   S_AXIS_TDATA,
    input  logic [NUM_SRC*DATA_W/8-1:0] S_AXIS_TKEEP,
    input  logic [NUM_SRC-1:0]          S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]          S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]          S_AXIS_TREADY,
    output logic [DATA_W-1:0]           M_AXIS_TDATA,
    output logic [DATA_W/8-1:0]         M_AXIS_TKEEP,
    output logic                        M_AXIS_TLAST,
    output logic [SEL_W-1:0]            M_AXIS_TDEST,
    output logic                        M_AXIS_TVALID,
`ifdef ARB_PKT_CNT_EN
    output logic [31:0]                 PKT_CNT,
`endif
    input  logic                        M_AXIS_TREADY
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PAY_W  = SEL_W + 1 + KEEP_W + DATA_W;

    arb_state_e        state;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  last_grant;
    logic [SEL_W-1:0]  grant_nxt;

    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_last;
    logic              sel_valid;
    logic              busy;
    logic              buf_ready;
    logic              accept;
    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  out_pay;

    assign grant_nxt = SEL_W'(rr_next(MAX_SRC'(S_AXIS_TVALID), 3'(last_grant), NUM_SRC));

    assign sel_data  = S_AXIS_TDATA[int'(grant)*DATA_W +: DATA_W];
    assign sel_keep  = S_AXIS_TKEEP[int'(grant)*KEEP_W +: KEEP_W];
    assign sel_last  = S_AXIS_TLAST[grant];
    assign sel_valid = S_AXIS_TVALID[grant];

    assign busy   = (state == ST_BUSY);
    assign accept = busy & sel_valid & buf_ready;
    assign in_pay = {grant, sel_last, sel_keep, sel_data};

    always_comb begin
        S_AXIS_TREADY = '0;
        if (busy) S_AXIS_TREADY[grant] = buf_ready;
    end

    // The grant stays locked through valid gaps; only an accepted TLAST releases it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= SEL_W'(NUM_SRC - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|S_AXIS_TVALID) begin
                        grant <= grant_nxt;
                        state <= ST_BUSY;
                    end
                end
                default: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    axis_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .in_data   (in_pay),
        .in_valid  (busy & sel_valid),
        .in_ready  (buf_ready),
        .out_data  (out_pay),
        .out_valid (M_AXIS_TVALID),
        .out_ready (M_AXIS_TREADY)
    );

    assign {M_AXIS_TDEST, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = out_pay;

`ifdef ARB_PKT_CNT_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) PKT_CNT <= 32'd0;
        else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) PKT_CNT <= PKT_CNT + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_bitflip_arb.sv
// Self-checking bench for axis_bitflip_arb: queue-driven sources, round-robin packet-order model.
module tb_axis_bitflip_arb;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 2;
    localparam int KEEP_W  = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_SRC*DATA_W-1:0] s_data;
    logic [NUM_SRC*KEEP_W-1:0] s_keep;
    logic [NUM_SRC-1:0]        s_last, s_valid, s_ready;
    logic [DATA_W-1:0]         m_data;
    logic [KEEP_W-1:0]         m_keep;
    logic                      m_last, m_valid, m_ready;
    logic [SEL_W-1:0]          m_dest;
`ifdef ARB_PKT_CNT_EN
    logic [31:0]               pkt_cnt;
`endif

    axis_bitflip_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TKEEP  (s_keep),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TKEEP  (m_keep),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TDEST  (m_dest),
        .M_AXIS_TVALID (m_valid),
`ifdef ARB_PKT_CNT_EN
        .PKT_CNT       (pkt_cnt),
`endif
        .M_AXIS_TREADY (m_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  dest;
    } obeat_t;

    beat_t  srcq[NUM_SRC][$];
    obeat_t exp_q[$];
    int     out_cyc[$];
    bit     newhead[NUM_SRC];
    bit     in_pkt[NUM_SRC];
    int     wait_cnt[NUM_SRC];
    logic [3:0] pat = 4'b1001;

    int n_checks = 0;
    int n_fail = 0;
    int cyc, n_out, pkts_out, pkts_total, stall_cnt;

    task automatic add_pkt(input int s, input int len, input logic [31:0] base, input logic [31:0] inc,
                           input int max_gap, input int gap_at, input int gap_len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + inc * k;
            b.keep = 4'($urandom);
            b.last = (k == len - 1);
            if (k == 0) b.gap = 0;
            else if (k == gap_at) b.gap = gap_len;
            else b.gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            srcq[s].push_back(b);
        end
    endtask

    // Reference order: after reset source 0 is first; each finished packet hands over to the
    // next source (modulo NUM_SRC) that still has a packet queued.
    task automatic build_expected();
        int ptr[NUM_SRC];
        int last;
        bit found;
        obeat_t o;
        exp_q.delete();
        for (int i = 0; i < NUM_SRC; i++) ptr[i] = 0;
        last = NUM_SRC - 1;
        found = 1;
        while (found) begin
            found = 0;
            for (int k = 1; k <= NUM_SRC && !found; k++) begin
                int s;
                s = (last + k) % NUM_SRC;
                if (ptr[s] < srcq[s].size()) begin
                    bit done;
                    done = 0;
                    while (!done) begin
                        o.data = srcq[s][ptr[s]].data;
                        o.keep = srcq[s][ptr[s]].keep;
                        o.last = srcq[s][ptr[s]].last;
                        o.dest = 2'(s);
                        exp_q.push_back(o);
                        done = o.last;
                        ptr[s]++;
                    end
                    last = s;
                    found = 1;
                end
            end
        end
    endtask

    task automatic drive_all(input int mode);
        for (int i = 0; i < NUM_SRC; i++) begin
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            s_data[i*DATA_W +: DATA_W] = '0;
            s_keep[i*KEEP_W +: KEEP_W] = '0;
            if (srcq[i].size() > 0) begin
                if (newhead[i]) begin
                    wait_cnt[i] = srcq[i][0].gap;
                    newhead[i] = 0;
                end
                if (wait_cnt[i] > 0) wait_cnt[i]--;
                else begin
                    s_valid[i] = 1'b1;
                    s_last[i]  = srcq[i][0].last;
                    s_data[i*DATA_W +: DATA_W] = srcq[i][0].data;
                    s_keep[i*KEEP_W +: KEEP_W] = srcq[i][0].keep;
                end
            end
        end
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = pat[cyc % 4];
            default: m_ready = ($urandom_range(99, 0) < 60);
        endcase
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        exp_q.delete();
        s_valid = '0; s_last = '0; s_data = '0; s_keep = '0; m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pkts_total = 0;
    endtask

    task automatic run(input int mode, input int stop_after, input int max_cycles);
        bit held, done;
        obeat_t h, e;
        logic [NUM_SRC-1:0] acc;
        held = 0; done = 0; cyc = 0; n_out = 0; pkts_out = 0; stall_cnt = 0;
        out_cyc.delete();
        for (int i = 0; i < NUM_SRC; i++) begin newhead[i] = 1; in_pkt[i] = 0; end
        drive_all(mode);
        while (!done) begin
            @(negedge clk);
            n_checks++;
            if ($countones(s_ready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot: got %b required at most one bit", s_ready);
            end
            for (int i = 0; i < NUM_SRC; i++)
                if (in_pkt[i] && s_valid[i] && !s_ready[i]) stall_cnt++;
            if (held) begin
                n_checks++;
                if (!m_valid || m_data !== h.data || m_keep !== h.keep || m_last !== h.last || m_dest !== h.dest) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b %h/%h/%b/%0d required v=1 %h/%h/%b/%0d",
                             m_valid, m_data, m_keep, m_last, m_dest, h.data, h.keep, h.last, h.dest);
                end
            end
            if (m_valid && m_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h dest %0d required no beat", m_data, m_dest);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last || m_dest !== e.dest) begin
                        n_fail++;
                        $display("FAIL out_beat: got %h/%h/%b/%0d required %h/%h/%b/%0d",
                                 m_data, m_keep, m_last, m_dest, e.data, e.keep, e.last, e.dest);
                    end
                end
                n_out++;
                out_cyc.push_back(cyc);
                if (m_last) begin pkts_out++; pkts_total++; end
            end
            held = m_valid && !m_ready;
            h.data = m_data; h.keep = m_keep; h.last = m_last; h.dest = m_dest;
            acc = s_valid & s_ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i]) begin
                    in_pkt[i] = !srcq[i][0].last;
                    void'(srcq[i].pop_front());
                    newhead[i] = 1;
                end
            end
            drive_all(mode);
            done = (exp_q.size() == 0);
            for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() != 0) done = 0;
            if (stop_after > 0 && n_out >= stop_after) done = 1;
            if (!done && cyc >= max_cycles) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: got %0d beats left after %0d cycles required 0", exp_q.size(), cyc);
                done = 1;
            end
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b0 || s_ready !== '0) begin
                n_fail++;
                $display("FAIL %s: got m_valid=%b s_ready=%b required 0/0", name, m_valid, s_ready);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || m_dest !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h/%b/%0d required all zero", m_data, m_keep, m_last, m_dest);
        end
        idle_check("reset_idle", 10);
`ifdef ARB_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt); end
`endif
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) add_pkt(i, 3, 32'hA0 + 32'(i), 32'd0, 0, -1, 0);
        build_expected();
        run(0, 0, 200);
        n_checks++;
        if (n_out != 12 || pkts_out != 4) begin
            n_fail++;
            $display("FAIL rr_counts: got %0d beats %0d pkts required 12 beats 4 pkts", n_out, pkts_out);
        end
        n_checks++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL rr_throughput: got %0d in-packet stalls required 0", stall_cnt);
        end
`ifdef ARB_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== 32'd4) begin n_fail++; $display("FAIL rr_pkt_cnt: got %0d required 4", pkt_cnt); end
`endif
        idle_check("rr_drained", 3);
    endtask

    task automatic test_grant_hold();
        do_reset();
        add_pkt(1, 1, 32'h100, 32'd1, 0, -1, 0);
        add_pkt(1, 2, 32'h110, 32'd1, 0, -1, 0);
        add_pkt(2, 4, 32'h200, 32'd1, 0, 2, 5);
        build_expected();
        run(0, 0, 200);
        n_checks++;
        if (pkts_out != 3) begin
            n_fail++;
            $display("FAIL hold_pkts: got %0d required 3", pkts_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(0, 6, 32'h11, 32'd1, 0, -1, 0);
        build_expected();
        run(1, 0, 200);
        n_checks++;
        if (n_out != 6) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d required 6", n_out);
        end
        n_checks++;
        if (stall_cnt == 0) begin
            n_fail++;
            $display("FAIL bp_ready_drop: got %0d full-buffer stalls required at least 1", stall_cnt);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int k = 0; k < 5; k++) add_pkt(3, 1, 32'h30 + 32'(k), 32'd0, 0, -1, 0);
        build_expected();
        run(0, 0, 200);
        for (int k = 1; k < out_cyc.size(); k++) begin
            n_checks++;
            if (out_cyc[k] - out_cyc[k-1] != 2) begin
                n_fail++;
                $display("FAIL single_beat_gap: got %0d cycles required 2", out_cyc[k] - out_cyc[k-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_pkt(0, 5, 32'h500, 32'd1, 0, -1, 0);
        build_expected();
        run(0, 2, 200);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b last=%b ready=%b required 0/0/0", m_valid, m_last, s_ready);
        end
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        exp_q.delete();
        s_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("reset_mid_flush", 4);
        add_pkt(1, 2, 32'h610, 32'd1, 0, -1, 0);
        add_pkt(0, 2, 32'h600, 32'd1, 0, -1, 0);
        build_expected();
        run(0, 0, 200);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < NUM_SRC; i++) begin
                int np;
                np = int'($urandom_range(3, 0));
                for (int p = 0; p < np; p++)
                    add_pkt(i, int'($urandom_range(5, 1)), $urandom, 32'($urandom_range(7, 1)), 2, -1, 0);
            end
            build_expected();
            run(2, 0, 2000);
`ifdef ARB_PKT_CNT_EN
            n_checks++;
            if (pkt_cnt !== 32'(pkts_total)) begin
                n_fail++;
                $display("FAIL rand_pkt_cnt: got %0d required %0d", pkt_cnt, pkts_total);
            end
`endif
        end
    endtask

    initial begin
        s_valid = '0; s_last = '0; s_data = '0; s_keep = '0; m_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_grant_hold();
        test_backpressure();
        test_single_beat();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
